// File: rtl/calc_port_scheduler.sv
// rtl/calc_port_scheduler.sv - four-port command scheduler in front of a shared ALU
//
// Ports:
//   c_clk, reset                       clock, asynchronous active-low reset
//   reqN_cmd_in / reqN_data_in         per-port command and operand stream (N=1..4)
//   out_respN / out_dataN              per-port one-cycle response pulse and result
//   alu_valid/alu_ready, alu_cmd/op1/op2/tag   issue channel to the shared ALU
//   alu_rsp_valid/rsp/rsp_data/rsp_tag          completion channel from the ALU
//   sched_err                          one-cycle pulse on a dropped ALU response
module calc_port_scheduler #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [31:0] req2_data_in,
    input  logic [31:0] req3_data_in,
    input  logic [31:0] req4_data_in,
    output logic [1:0]  out_resp1,
    output logic [1:0]  out_resp2,
    output logic [1:0]  out_resp3,
    output logic [1:0]  out_resp4,
    output logic [31:0] out_data1,
    output logic [31:0] out_data2,
    output logic [31:0] out_data3,
    output logic [31:0] out_data4,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic [3:0]  alu_cmd,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [1:0]  alu_tag,
    input  logic        alu_rsp_valid,
    input  logic [1:0]  alu_rsp,
    input  logic [31:0] alu_rsp_data,
    input  logic [1:0]  alu_rsp_tag,
    output logic        sched_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OP2  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]  r_state [4];
    logic [3:0]  r_cmd   [4];
    logic [31:0] r_op1   [4];
    logic [31:0] r_op2   [4];
    logic [1:0]  r_resp  [4];
    logic [31:0] r_data  [4];
    logic [1:0]  r_last;
    logic        r_stall;
    logic [1:0]  r_stall_idx;
    logic        r_err;

    logic [3:0]  w_cmd_in  [4];
    logic [31:0] w_data_in [4];
    logic [3:0]  w_pend;
    logic        w_any;
    logic        w_found;
    logic [1:0]  w_gnt;
    logic [1:0]  w_idx;
    logic        w_fire;
    logic        w_rsp_ok;
    logic        w_rsp_bad;

    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        return (cmd == 4'd1) || (cmd == 4'd2) || (cmd == 4'd5) || (cmd == 4'd6);
    endfunction

    assign w_cmd_in[0]  = req1_cmd_in;
    assign w_cmd_in[1]  = req2_cmd_in;
    assign w_cmd_in[2]  = req3_cmd_in;
    assign w_cmd_in[3]  = req4_cmd_in;
    assign w_data_in[0] = req1_data_in;
    assign w_data_in[1] = req2_data_in;
    assign w_data_in[2] = req3_data_in;
    assign w_data_in[3] = req4_data_in;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_pend[i] = (r_state[i] == S_PEND);
        end
    end

    assign w_any = |w_pend;

    // A stalled offer keeps its grant: newly pending ports must not steal the
    // slot while the payload is being held for the ALU.
    always_comb begin
        w_gnt   = 2'd0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        if (r_stall) begin
            w_gnt = r_stall_idx;
        end else if (FIXED_PRIO != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (!w_found && w_pend[i]) begin
                    w_gnt   = 2'(i);
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                w_idx = r_last + 2'(k + 1);
                if (!w_found && w_pend[w_idx]) begin
                    w_gnt   = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign alu_valid = w_any;
    assign alu_cmd   = w_any ? r_cmd[w_gnt] : 4'd0;
    assign alu_op1   = w_any ? r_op1[w_gnt] : 32'd0;
    assign alu_op2   = w_any ? r_op2[w_gnt] : 32'd0;
    assign alu_tag   = w_any ? w_gnt : 2'd0;
    assign w_fire    = w_any & alu_ready;

    // Only a port waiting on its result may accept a response; a 00 code is
    // never a legal completion.
    assign w_rsp_ok  = alu_rsp_valid && (r_state[alu_rsp_tag] == S_WAIT) && (alu_rsp != 2'b00);
    assign w_rsp_bad = alu_rsp_valid && !w_rsp_ok;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= S_IDLE;
                r_cmd[i]   <= 4'd0;
                r_op1[i]   <= 32'd0;
                r_op2[i]   <= 32'd0;
                r_resp[i]  <= 2'b00;
                r_data[i]  <= 32'd0;
            end
            r_last      <= 2'd3;
            r_stall     <= 1'b0;
            r_stall_idx <= 2'd0;
            r_err       <= 1'b0;
        end else begin
            r_err       <= w_rsp_bad;
            r_stall     <= w_any & ~alu_ready;
            r_stall_idx <= w_gnt;
            if (w_fire) begin
                r_last <= w_gnt;
            end
            for (int i = 0; i < 4; i++) begin
                r_resp[i] <= 2'b00;
                r_data[i] <= 32'd0;
                case (r_state[i])
                    S_IDLE: begin
                        if (w_cmd_in[i] != 4'd0) begin
                            r_state[i] <= S_OP2;
                            r_cmd[i]   <= w_cmd_in[i];
                            r_op1[i]   <= w_data_in[i];
                        end
                    end
                    S_OP2: begin
                        r_op2[i] <= w_data_in[i];
                        if (cmd_is_valid(r_cmd[i])) begin
                            r_state[i] <= S_PEND;
                        end else begin
                            r_state[i] <= S_IDLE;
                            r_resp[i]  <= 2'b11;
                        end
                    end
                    S_PEND: begin
                        if (w_fire && (w_gnt == 2'(i))) begin
                            r_state[i] <= S_WAIT;
                        end
                    end
                    default: begin
                        if (w_rsp_ok && (alu_rsp_tag == 2'(i))) begin
                            r_state[i] <= S_IDLE;
                            r_resp[i]  <= alu_rsp;
                            r_data[i]  <= alu_rsp_data;
                        end
                    end
                endcase
            end
        end
    end

    assign out_resp1 = r_resp[0];
    assign out_resp2 = r_resp[1];
    assign out_resp3 = r_resp[2];
    assign out_resp4 = r_resp[3];
    assign out_data1 = r_data[0];
    assign out_data2 = r_data[1];
    assign out_data3 = r_data[2];
    assign out_data4 = r_data[3];
    assign sched_err = r_err;

endmodule
